// File: rtl/wb_cache_pkg.sv
// Shared types and geometry helpers for the write-back cache controller.
// Field helpers take widths as arguments so any cache geometry can use them.
package wb_cache_pkg;

  typedef enum logic [1:0] {IDLE, COMPARE, WBACK, ALLOCATE} state_t;

  function automatic int unsigned byte_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_w, input int unsigned data_w,
                                           input int unsigned num_lines, input int unsigned line_words);
    return addr_w - $clog2(num_lines) - $clog2(line_words) - byte_bits(data_w);
  endfunction

  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int unsigned lsb,
                                             input int unsigned width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] get_offset(input logic [63:0] addr, input int unsigned byte_w,
                                             input int unsigned offset_w);
    return addr_field(addr, byte_w, offset_w);
  endfunction

  function automatic logic [63:0] get_index(input logic [63:0] addr, input int unsigned byte_w,
                                            input int unsigned offset_w, input int unsigned index_w);
    return addr_field(addr, byte_w + offset_w, index_w);
  endfunction

  function automatic logic [63:0] get_tag(input logic [63:0] addr, input int unsigned addr_w,
                                          input int unsigned tag_w);
    return addr_field(addr, addr_w - tag_w, tag_w);
  endfunction

endpackage

// File: rtl/cache_line_xfer.sv
// Line burst engine: word counter and mem_req/mem_ack handshake shared by
// writeback and allocate. mem_req stays low for a cycle after every burst.
module cache_line_xfer
  import wb_cache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned OFFSET_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic [OFFSET_W-1:0] word_cnt,
  output logic                burst_done
);

  logic busy;

  assign mem_req    = busy;
  assign burst_done = busy && mem_ack && (word_cnt == OFFSET_W'(LINE_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      word_cnt <= '0;
    end else if (!busy) begin
      busy     <= go;
      word_cnt <= '0;
    end else if (mem_ack) begin
      // Counter wraps to 0 naturally on the last word of a power-of-2 line.
      word_cnt <= word_cnt + OFFSET_W'(1);
      if (burst_done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache with req/ack memory port.
// Optional per-word parity checking is enabled by defining CACHE_PARITY_EN.
module wb_cache_ctrl
  import wb_cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd_en,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
`ifdef CACHE_PARITY_EN
  ,
  input  logic              par_inj,
  output logic              par_err,
  output logic              par_err_sticky
`endif
);

  localparam int unsigned BYTE_W   = byte_bits(DATA_W);
  localparam int unsigned OFFSET_W = $clog2(LINE_WORDS);
  localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W    = tag_bits(ADDR_W, DATA_W, NUM_LINES, LINE_WORDS);
  localparam int unsigned WORDS    = NUM_LINES * LINE_WORDS;

  logic [TAG_W-1:0]    tag_mem  [NUM_LINES];
  logic [DATA_W-1:0]   data_mem [WORDS];
  logic [NUM_LINES-1:0] valid, dirty;

  state_t              state, state_nxt;
  logic [TAG_W-1:0]    req_tag, miss_tag, line_tag;
  logic [INDEX_W-1:0]  req_idx, miss_idx;
  logic [OFFSET_W-1:0] req_off, word_cnt;
  logic                req, raw_hit, hit, lookup, served, store_hit;
  logic                xfer_go, xfer_done, fill_we;

  assign req_tag = TAG_W'(get_tag(64'(cpu_addr), ADDR_W, TAG_W));
  assign req_idx = INDEX_W'(get_index(64'(cpu_addr), BYTE_W, OFFSET_W, INDEX_W));
  assign req_off = OFFSET_W'(get_offset(64'(cpu_addr), BYTE_W, OFFSET_W));

  assign req       = cpu_rd_en || cpu_wr_en;
  assign raw_hit   = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign lookup    = (state == IDLE) && req;
  assign served    = lookup && hit;
  assign store_hit = served && cpu_wr_en;
  assign cpu_rdata = data_mem[{req_idx, req_off}];
  assign cpu_stall = req && !((state == IDLE) && hit);

  assign xfer_go = (state == WBACK) || (state == ALLOCATE);
  assign fill_we = (state == ALLOCATE) && mem_req && mem_ack;

  cache_line_xfer #(
    .LINE_WORDS(LINE_WORDS),
    .OFFSET_W  (OFFSET_W)
  ) u_xfer (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (xfer_go),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .word_cnt  (word_cnt),
    .burst_done(xfer_done)
  );

  // Writeback addresses use the resident tag; fills use the latched miss tag.
  assign line_tag  = (state == WBACK) ? tag_mem[miss_idx] : miss_tag;
  assign mem_we    = mem_req && (state == WBACK);
  assign mem_addr  = ADDR_W'({line_tag, miss_idx, word_cnt}) << BYTE_W;
  assign mem_wdata = data_mem[{miss_idx, word_cnt}];

`ifdef CACHE_PARITY_EN
  logic [WORDS-1:0] par_mem;
  logic             par_bad;

  // A clean line with bad parity is simply refetched; dirty data is the only copy.
  assign par_bad = cpu_rd_en && !cpu_wr_en && raw_hit &&
                   ((^cpu_rdata) != par_mem[{req_idx, req_off}]);
  assign hit     = raw_hit && !(par_bad && !dirty[req_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err        <= 1'b0;
      par_err_sticky <= 1'b0;
    end else begin
      par_err <= lookup && par_bad;
      if (lookup && par_bad && dirty[req_idx]) par_err_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (store_hit)    par_mem[{req_idx, req_off}]   <= (^cpu_wdata) ^ par_inj;
    else if (fill_we) par_mem[{miss_idx, word_cnt}] <= ^mem_rdata;
  end
`else
  assign hit = raw_hit;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (req && !hit) state_nxt = COMPARE;
      COMPARE:  state_nxt = (valid[miss_idx] && dirty[miss_idx]) ? WBACK : ALLOCATE;
      WBACK:    if (xfer_done) state_nxt = ALLOCATE;
      ALLOCATE: if (xfer_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (lookup && !hit) begin
        miss_tag <= req_tag;
        miss_idx <= req_idx;
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      end
      if (served && (hit_cnt != '1)) hit_cnt <= hit_cnt + CNT_W'(1);
      if (store_hit) dirty[req_idx] <= 1'b1;
      if ((state == ALLOCATE) && xfer_done) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ALLOCATE) && xfer_done) tag_mem[miss_idx] <= miss_tag;
    if (store_hit)    data_mem[{req_idx, req_off}]   <= cpu_wdata;
    else if (fill_we) data_mem[{miss_idx, word_cnt}] <= mem_rdata;
  end

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Bench for wb_cache_ctrl: directed vector table, reset/withdraw sequences and
// random traffic checked against a transparent-memory reference model.
module tb_wb_cache_ctrl;

  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_rd_en, cpu_wr_en;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
  logic              cpu_stall;
  logic              mem_req, mem_we, mem_ack;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  wb_cache_ctrl #(
    .ADDR_W(32), .DATA_W(32), .NUM_LINES(64), .LINE_WORDS(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- memory, truth and cache-occupancy model ----------------
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } xfer_t;
  xfer_t act_q[$];
  xfer_t exp_q[$];

  logic [31:0] ext_mem [logic [31:0]];
  logic [31:0] truth   [logic [31:0]];

  bit          m_valid [64];
  bit          m_dirty [64];
  logic [31:0] m_tag   [64];
  int          m_hits, m_misses;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a * 32'h0100_0193 + 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ext_rd(input logic [31:0] a);
    return ext_mem.exists(a) ? ext_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] truth_rd(input logic [31:0] a);
    return truth.exists(a) ? truth[a] : init_val(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = '0;
    end
    m_hits   = 0;
    m_misses = 0;
    truth.delete();
    foreach (ext_mem[k]) truth[k] = ext_mem[k];
  endtask

  // Predicts hit/miss and, on a miss, the whole expected transfer sequence.
  task automatic predict(input logic [31:0] a, output bit miss);
    int unsigned idx;
    logic [31:0] tag, wa;
    idx  = (a >> 5) & 63;
    tag  = a >> 11;
    miss = !(m_valid[idx] && m_tag[idx] == tag);
    if (miss) begin
      if (m_misses < SAT) m_misses++;
      if (m_valid[idx] && m_dirty[idx])
        for (int w = 0; w < 8; w++) begin
          wa = (m_tag[idx] << 11) | (idx << 5) | (w << 2);
          exp_q.push_back('{1'b1, wa, truth_rd(wa)});
        end
      for (int w = 0; w < 8; w++) begin
        wa = (tag << 11) | (idx << 5) | (w << 2);
        exp_q.push_back('{1'b0, wa, 32'h0});
      end
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tag;
    end
  endtask

  task automatic check_xfers();
    int n;
    chk("xfer_count", 32'(act_q.size()), 32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("xfer_we", 32'(act_q[i].we), 32'(exp_q[i].we));
      chk("xfer_addr", act_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) chk("xfer_wdata", act_q[i].wdata, exp_q[i].wdata);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  // ---------------- memory responder ----------------
  int          lat = 1;
  int          wcnt;
  bit          pend, ack_we, p_we;
  logic [31:0] p_addr;

  initial begin
    mem_ack = 0; mem_rdata = '0; pend = 0; ack_we = 0; wcnt = 0; p_we = 0; p_addr = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 0;
      if (!rst_n) begin
        pend = 0; ack_we = 0; wcnt = 0;
      end else begin
        if (pend) begin
          chk("req_held", 32'(mem_req), 32'd1);
          chk("addr_held", mem_addr, p_addr);
          chk("we_held", 32'(mem_we), 32'(p_we));
        end
        if (ack_we) chk("burst_gap", 32'(mem_req && !mem_we), 32'd0);
        pend = 0; ack_we = 0;
        if (mem_req) begin
          if (wcnt >= lat) begin
            mem_ack = 1;
            wcnt    = 0;
            act_q.push_back('{mem_we, mem_addr, mem_wdata});
            if (mem_we) begin
              ext_mem[mem_addr] = mem_wdata;
              ack_we = 1;
            end else begin
              mem_rdata = ext_rd(mem_addr);
            end
          end else begin
            wcnt++;
            pend = 1; p_addr = mem_addr; p_we = mem_we;
          end
        end
      end
    end
  end

  // ---------------- CPU access ----------------
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input int l, input int exp_stall_tbl, input int exp_wb_tbl);
    bit          miss;
    logic [31:0] exp_rd;
    int          cyc, nw;
    int unsigned idx;
    lat = l;
    idx = (a >> 5) & 63;
    predict(a, miss);
    exp_rd = truth_rd(a);
    @(negedge clk);
    cpu_rd_en = rd; cpu_wr_en = wr; cpu_addr = a; cpu_wdata = wd;
    #1;
    chk("first_stall", 32'(cpu_stall), (exp_stall_tbl >= 0) ? 32'(exp_stall_tbl) : 32'(miss));
    cyc = 0;
    while (cpu_stall && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (cpu_stall) fail_now("stall_timeout");
    chk("rdata", cpu_rdata, exp_rd);
    @(posedge clk); #2;
    if (m_hits < SAT) m_hits++;
    if (wr) begin
      truth[a]     = wd;
      m_dirty[idx] = 1;
    end
    cpu_rd_en = 0; cpu_wr_en = 0;
    chk("hit_cnt", 32'(hit_cnt), 32'(m_hits));
    chk("miss_cnt", 32'(miss_cnt), 32'(m_misses));
    if (exp_wb_tbl >= 0) begin
      nw = 0;
      foreach (act_q[i]) if (act_q[i].we) nw++;
      chk("wb_count", 32'(nw), 32'(exp_wb_tbl));
    end
    check_xfers();
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_stall;
    int          exp_wb;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int          cyc, nrd, op;
    bit          miss;
    logic [31:0] a;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1, 1, 0};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1, 0, 0};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEADBEEF,  1, 0, 0};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0844, 32'h0,         1, 1, 8};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         5, 1, 0};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_0048, 32'h1234_5678, 5, 0, 0};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,         1, 0, 0};
    tbl[7] = '{1'b1, 1'b0, 32'h0000_1040, 32'h0,         5, 1, 8};

    rst_n = 0; cpu_rd_en = 0; cpu_wr_en = 0; cpu_addr = '0; cpu_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk); #1;
    chk("reset_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("reset_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("reset_stall", 32'(cpu_stall), 32'd0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);

    for (int i = 0; i < 8; i++)
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].lat,
                tbl[i].exp_stall, tbl[i].exp_wb);

    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 2);
      a  = ($urandom_range(0, 3) << 11) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      do_access(op != 1, op != 0, a, $urandom, $urandom_range(0, 3), -1, -1);
    end

    // Request withdrawn mid-fill: the line must still end up resident.
    a = 32'h0000_3060;
    lat = 1;
    predict(a, miss);
    @(negedge clk);
    cpu_rd_en = 1; cpu_addr = a;
    #1;
    chk("wd_stall", 32'(cpu_stall), 32'd1);
    cyc = 0;
    while (act_q.size() < exp_q.size() - 6 && cyc < 400) begin @(negedge clk); cyc++; end
    if (cyc >= 400) fail_now("wd_wait_start");
    cpu_rd_en = 0;
    cyc = 0;
    while ((act_q.size() < exp_q.size() || mem_req) && cyc < 400) begin @(negedge clk); cyc++; end
    if (cyc >= 400) fail_now("wd_wait_done");
    repeat (3) @(negedge clk);
    chk("wd_miss_cnt", 32'(miss_cnt), 32'(m_misses));
    chk("wd_hit_cnt", 32'(hit_cnt), 32'(m_hits));
    check_xfers();
    do_access(1, 0, a, 32'h0, 1, 0, 0);

    // Reset during the fourth allocate word.
    a = 32'h0000_2040;
    lat = 2;
    act_q.delete();
    @(negedge clk);
    cpu_rd_en = 1; cpu_addr = a;
    cyc = 0;
    nrd = 0;
    while (!(nrd >= 3 && mem_req && !mem_we) && cyc < 400) begin
      @(negedge clk);
      nrd = 0;
      foreach (act_q[i]) if (!act_q[i].we) nrd++;
      cyc++;
    end
    if (cyc >= 400) fail_now("rst_wait_alloc");
    rst_n = 0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd1);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    cpu_rd_en = 0;
    rst_n = 1;
    act_q.delete();
    exp_q.delete();
    model_reset();
    do_access(1, 0, a, 32'h0, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
